// File: rtl/relu_maxpool_col.sv
// Column-streaming FP16 ReLU followed by 2x2 / stride-2 max-pool.
// Two input columns in, one half-height pooled column out, one cycle after the odd column.
module relu_maxpool_col #(
  parameter  int DATA_WIDTH = 16,
  parameter  int IN_ROWS    = 24,
  parameter  int IN_COLS    = 24,
  localparam int OUT_ROWS   = IN_ROWS / 2,
  localparam int OUT_COLS   = IN_COLS / 2,
  localparam int COL_W      = $clog2(OUT_COLS) + 1,
  localparam int CNT_W      = $clog2(2 * OUT_COLS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data  [IN_ROWS],
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data [OUT_ROWS],
  output logic [COL_W-1:0]      out_col,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EVEN = 2'd1,
    WAIT_ODD  = 2'd2
  } state_t;

  state_t                  state_r, state_next_s;
  logic                    accept_s, last_s;
  logic [CNT_W-1:0]        col_cnt_r;
  logic [DATA_WIDTH-1:0]   v_s        [OUT_ROWS];
  logic [DATA_WIDTH-1:0]   pair_buf_r [OUT_ROWS];
  logic [DATA_WIDTH-1:0]   out_data_r [OUT_ROWS];
  logic [COL_W-1:0]        out_col_r;
  logic                    out_valid_r, done_r;

  // Negative values (incl. -0, -Inf) and NaN clamp to +0; +Inf passes.
  function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] x);
    logic is_nan;
    is_nan = (x[DATA_WIDTH-2 -: 5] == 5'h1F) && (x[DATA_WIDTH-7:0] != {(DATA_WIDTH-6){1'b0}});
    if (x[DATA_WIDTH-1] || is_nan) begin
      return {DATA_WIDTH{1'b0}};
    end else begin
      return x;
    end
  endfunction

  // Operands are non-negative after ReLU, so an unsigned compare orders them.
  function automatic logic [DATA_WIDTH-1:0] fmax(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    if (a[DATA_WIDTH-2:0] >= b[DATA_WIDTH-2:0]) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  // Vertical pool of row pairs straight off the input bus.
  always_comb begin
    for (int i = 0; i < OUT_ROWS; i++) begin
      v_s[i] = fmax(relu(in_data[2*i]), relu(in_data[2*i+1]));
    end
  end

  // Frame state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; start overrides any in_valid in the same cycle.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    last_s       = 1'b0;
    if (start) begin
      state_next_s = WAIT_EVEN;
    end else begin
      case (state_r)
        IDLE: begin
          state_next_s = IDLE;
        end
        WAIT_EVEN: begin
          if (in_valid) begin
            accept_s     = 1'b1;
            state_next_s = WAIT_ODD;
          end else begin
            state_next_s = WAIT_EVEN;
          end
        end
        WAIT_ODD: begin
          if (in_valid) begin
            accept_s = 1'b1;
            last_s   = (col_cnt_r == CNT_W'(2 * OUT_COLS - 1));
            if (last_s) begin
              state_next_s = IDLE;
            end else begin
              state_next_s = WAIT_EVEN;
            end
          end else begin
            state_next_s = WAIT_ODD;
          end
        end
        default: begin
          state_next_s = IDLE;
        end
      endcase
    end
  end

  // Column counter, pair buffer and registered pooled output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt_r   <= {CNT_W{1'b0}};
      out_col_r   <= {COL_W{1'b0}};
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
      for (int i = 0; i < OUT_ROWS; i++) begin
        pair_buf_r[i] <= {DATA_WIDTH{1'b0}};
        out_data_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
      if (start) begin
        col_cnt_r <= {CNT_W{1'b0}};
        out_col_r <= {COL_W{1'b0}};
        for (int i = 0; i < OUT_ROWS; i++) begin
          pair_buf_r[i] <= {DATA_WIDTH{1'b0}};
        end
      end else if (accept_s) begin
        col_cnt_r <= col_cnt_r + CNT_W'(1);
        if (state_r == WAIT_EVEN) begin
          pair_buf_r <= v_s;
        end else begin
          for (int i = 0; i < OUT_ROWS; i++) begin
            out_data_r[i] <= fmax(pair_buf_r[i], v_s[i]);
          end
          out_valid_r <= 1'b1;
          out_col_r   <= COL_W'(col_cnt_r >> 1);
          done_r      <= last_s;
        end
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_col   = out_col_r;
  assign done      = done_r;
  assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_relu_maxpool_col.sv
// Directed bench for relu_maxpool_col: expected pooled columns are queued at
// stimulus time and popped when out_valid appears.
module tb_relu_maxpool_col;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data  [24];
  logic        out_valid;
  logic [15:0] out_data [12];
  logic [4:0]  out_col;
  logic        busy, done;

  logic        s_start = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data     [4];
  logic        s_out_valid;
  logic [15:0] s_out_data [2];
  logic [1:0]  s_out_col;
  logic        s_busy, s_done;

  typedef struct packed {
    logic [12*16-1:0] d;
    logic [4:0]       col;
    logic             dn;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  logic [15:0] neg_v [4];

  always #5 clk = ~clk;

  relu_maxpool_col dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_col(out_col), .busy(busy), .done(done)
  );

  relu_maxpool_col #(.IN_ROWS(4), .IN_COLS(5)) dut5 (
    .clk(clk), .rst(rst), .start(s_start), .in_valid(s_valid), .in_data(s_data),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_col(s_out_col), .busy(s_busy), .done(s_done)
  );

  // FP16 encoding of n/8 for small non-negative integers n.
  function automatic logic [15:0] fp8(input int n);
    int e;
    logic [15:0] r;
    r = 16'h0000;
    if (n > 0) begin
      e = 0;
      for (int b = 0; b < 16; b++) if ((n >> b) != 0) e = b;
      r = {1'b0, 5'(e + 12), 10'((n << (10 - e)) & 32'h3FF)};
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ramp(input int c);
    for (int r = 0; r < 24; r++) in_data[r] = fp8(c + r);
  endtask

  task automatic push_ramp(input int k);
    exp_t e;
    for (int i = 0; i < 12; i++) e.d[i*16 +: 16] = fp8(2*k + 2*i + 2);
    e.col = 5'(k);
    e.dn  = (k == 11);
    q.push_back(e);
  endtask

  // One clock of stimulus; output sampled 1 time unit after the edge.
  task automatic drive(input bit st, input bit v);
    exp_t e;
    bit   exp_v;
    start    = st;
    in_valid = v;
    exp_v    = (q.size() > 0);
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
    if (exp_v) begin
      e = q.pop_front();
      check("out_col", {27'd0, out_col}, {27'd0, e.col});
      check("done", {31'd0, done}, {31'd0, e.dn});
      for (int i = 0; i < 12; i++)
        check($sformatf("out_data[%0d]", i), {16'd0, out_data[i]}, {16'd0, e.d[i*16 +: 16]});
    end else begin
      check("done_idle", {31'd0, done}, 32'd0);
    end
  endtask

  task automatic run_frame(input int gap_max, input bit start_with_valid);
    set_ramp(0);
    drive(1'b1, start_with_valid);
    check("busy_start", {31'd0, busy}, 32'd1);
    for (int c = 0; c < 24; c++) begin
      int gaps;
      gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      for (int g = 0; g < gaps; g++) drive(1'b0, 1'b0);
      set_ramp(c);
      if (c % 2 == 1) push_ramp(c / 2);
      drive(1'b0, 1'b1);
    end
    check("busy_end", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    exp_t e;
    for (int r = 0; r < 24; r++) in_data[r] = 16'h0000;
    for (int r = 0; r < 4; r++) s_data[r] = 16'h0000;
    neg_v[0] = 16'hBC00; neg_v[1] = 16'h8000; neg_v[2] = 16'h7E00; neg_v[3] = 16'hFC00;
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_col", {27'd0, out_col}, 32'd0);
    for (int i = 0; i < 12; i++) check("rst_out_data", {16'd0, out_data[i]}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Plain ramp frame.
    run_frame(0, 1'b0);

    // ReLU: negatives, -0, NaN, -Inf all clamp; +Inf survives.
    drive(1'b1, 1'b0);
    for (int r = 0; r < 24; r++) in_data[r] = neg_v[r % 4];
    drive(1'b0, 1'b1);
    for (int r = 0; r < 24; r++) in_data[r] = neg_v[(r + 1) % 4];
    e.d = '0; e.col = 5'd0; e.dn = 1'b0;
    q.push_back(e);
    drive(1'b0, 1'b1);
    for (int r = 0; r < 24; r++) in_data[r] = 16'h3C00;
    in_data[0] = 16'h7C00;
    drive(1'b0, 1'b1);
    for (int r = 0; r < 24; r++) in_data[r] = 16'h3C00;
    for (int i = 0; i < 12; i++) e.d[i*16 +: 16] = 16'h3C00;
    e.d[15:0] = 16'h7C00; e.col = 5'd1; e.dn = 1'b0;
    q.push_back(e);
    drive(1'b0, 1'b1);

    // Gapped ramp.
    run_frame(3, 1'b0);

    // Abort after 5 columns, then a full frame.
    drive(1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      set_ramp(c);
      if (c % 2 == 1) push_ramp(c / 2);
      drive(1'b0, 1'b1);
    end
    run_frame(0, 1'b0);

    // Reset one cycle after an even column.
    drive(1'b1, 1'b0);
    set_ramp(0);
    drive(1'b0, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_out_col", {27'd0, out_col}, 32'd0);
    for (int i = 0; i < 12; i++) check("mid_rst_out_data", {16'd0, out_data[i]}, 32'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    set_ramp(1);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    check("idle_busy", {31'd0, busy}, 32'd0);
    // start together with in_valid: that column must not be counted.
    run_frame(0, 1'b1);

    // IN_COLS=5 instance: two pairs, fifth column dropped.
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      for (int r = 0; r < 4; r++) s_data[r] = fp8(c + r);
      s_valid = 1'b1;
      @(posedge clk); #1;
      s_valid = 1'b0;
      check("c5_out_valid", {31'd0, s_out_valid}, {31'd0, (c == 1 || c == 3)});
      check("c5_done", {31'd0, s_done}, {31'd0, (c == 3)});
      if (c == 1 || c == 3) begin
        check("c5_out_col", {30'd0, s_out_col}, 32'(c / 2));
        for (int i = 0; i < 2; i++)
          check("c5_out_data", {16'd0, s_out_data[i]}, {16'd0, fp8(c + 2*i + 1)});
      end
      if (c >= 3) check("c5_busy", {31'd0, s_busy}, 32'd0);
    end
    check("queue_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
